// File: rtl/scan_reg_pkg.sv
// Shared types and elaboration helpers for the scan register bank.
//   state_t   : auto-shift sequencer states (IDLE, SHIFT, DONE)
//   chain_len : bits per scan chain for a given width / chain count
//   cnt_width : width of the sequencer down-counter for a chain length
//   cfg_ok    : legal width / chain-count combination
package scan_reg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int chain_len(input int width, input int num_chains);
      return width / num_chains;
   endfunction

   // A chain of length 1 still needs a one-bit counter.
   function automatic int cnt_width(input int l);
      int c;
      c = $clog2(l);
      return (c < 1) ? 1 : c;
   endfunction

   function automatic bit cfg_ok(input int width, input int num_chains);
      return (num_chains >= 1) && (width >= num_chains) && ((width % num_chains) == 0);
   endfunction

endpackage

// File: rtl/scan_shift_ctrl.sv
// Auto-shift sequencer: on SHIFT_START from IDLE, asserts shift_active for
// exactly L clock edges, then pulses SHIFT_DONE for one cycle.
//   CK, RST      : clock, asynchronous active-high reset
//   SHIFT_START  : single-cycle request, ignored unless IDLE
//   shift_active : register bank must shift on the coming edge
//   SHIFT_BUSY   : registered decode of SHIFT state
//   SHIFT_DONE   : registered decode of DONE state
module scan_shift_ctrl
   import scan_reg_pkg::*;
#(
   parameter int L  = 4,
   parameter int CW = 2
) (
   input  logic CK,
   input  logic RST,
   input  logic SHIFT_START,
   output logic shift_active,
   output logic SHIFT_BUSY,
   output logic SHIFT_DONE
);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            busy_r;
   logic            done_r;

   // Outputs are registered alongside the state so nothing combinational
   // from the inputs reaches them.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (SHIFT_START) begin
                  state  <= SHIFT;
                  cnt    <= CW'(L - 1);
                  busy_r <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            SHIFT: begin
               // Counter runs L-1 down to 0, one shift edge per value.
               if (cnt == '0) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign shift_active = busy_r;
   assign SHIFT_BUSY   = busy_r;
   assign SHIFT_DONE   = done_r;

endmodule

// File: rtl/scan_reg_bank.sv
// Multi-bit, multi-chain mux-scan register with functional load enable and
// a built-in sequencer that performs a full chain-length shift per start.
//   CK, RST     : clock, asynchronous active-high reset (Q <= RESET_VAL)
//   D, EN       : functional data and load enable
//   SE, SI      : external scan enable, scan-in (one bit per chain)
//   SHIFT_START : request an automatic L-edge shift
//   Q, QN       : register state and its complement
//   SO          : scan-out, top bit of each chain
//   SHIFT_BUSY  : auto-shift in progress
//   SHIFT_DONE  : one-cycle pulse after the last auto-shift edge
// Edge priority: shift (SE or sequencer) > load (EN) > hold.
module scan_reg_bank
   import scan_reg_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter int               NUM_CHAINS = 1,
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
   input  logic                  CK,
   input  logic                  RST,
   input  logic [WIDTH-1:0]      D,
   input  logic                  EN,
   input  logic                  SE,
   input  logic [NUM_CHAINS-1:0] SI,
   input  logic                  SHIFT_START,
   output logic [WIDTH-1:0]      Q,
   output logic [WIDTH-1:0]      QN,
   output logic [NUM_CHAINS-1:0] SO,
   output logic                  SHIFT_BUSY,
   output logic                  SHIFT_DONE
);

   localparam int L  = chain_len(WIDTH, NUM_CHAINS);
   localparam int CW = cnt_width(L);

   generate
      if (!cfg_ok(WIDTH, NUM_CHAINS)) begin : g_bad_cfg
         $error("scan_reg_bank: WIDTH must be a non-zero multiple of NUM_CHAINS");
      end
   endgenerate

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] shifted;
   logic             shift_active;
   logic             do_shift;

   scan_shift_ctrl #(
      .L  (L),
      .CW (CW)
   ) u_ctrl (
      .CK           (CK),
      .RST          (RST),
      .SHIFT_START  (SHIFT_START),
      .shift_active (shift_active),
      .SHIFT_BUSY   (SHIFT_BUSY),
      .SHIFT_DONE   (SHIFT_DONE)
   );

   // SE and the sequencer merge into one shift, never two per edge.
   assign do_shift = SE | shift_active;

   // Each chain shifts toward its MSB; SI enters at the chain LSB.
   always_comb begin
      shifted = q;
      for (int c = 0; c < NUM_CHAINS; c++) begin
         shifted[c*L] = SI[c];
         for (int i = 1; i < L; i++) begin
            shifted[c*L+i] = q[c*L+i-1];
         end
      end
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         q <= RESET_VAL;
      end else if (do_shift) begin
         q <= shifted;
      end else if (EN) begin
         q <= D;
      end
   end

   for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_so
      assign SO[c] = q[c*L+L-1];
   end

   assign Q  = q;
   assign QN = ~q;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed bench for scan_reg_bank (WIDTH=8, NUM_CHAINS=2, L=4).
// Expected register/status values are queued as stimulus is driven and
// popped one entry per clock edge, then compared on the falling edge.
module tb_scan_reg_bank;

   logic       CK;
   logic       RST;
   logic [7:0] D;
   logic       EN;
   logic       SE;
   logic [1:0] SI;
   logic       SHIFT_START;
   logic [7:0] Q;
   logic [7:0] QN;
   logic [1:0] SO;
   logic       SHIFT_BUSY;
   logic       SHIFT_DONE;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   scan_reg_bank #(
      .WIDTH      (8),
      .NUM_CHAINS (2),
      .RESET_VAL  (8'h00)
   ) dut (
      .CK          (CK),
      .RST         (RST),
      .D           (D),
      .EN          (EN),
      .SE          (SE),
      .SI          (SI),
      .SHIFT_START (SHIFT_START),
      .Q           (Q),
      .QN          (QN),
      .SO          (SO),
      .SHIFT_BUSY  (SHIFT_BUSY),
      .SHIFT_DONE  (SHIFT_DONE)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] q, input logic busy, input logic done);
      chk({tag, ".Q"},    Q, q);
      chk({tag, ".QN"},   QN, ~q);
      chk({tag, ".SO"},   {6'd0, SO}, {6'd0, q[7], q[3]});
      chk({tag, ".BUSY"}, {7'd0, SHIFT_BUSY}, {7'd0, busy});
      chk({tag, ".DONE"}, {7'd0, SHIFT_DONE}, {7'd0, done});
   endtask

   task automatic push(input string tag, input logic [7:0] q, input logic busy, input logic done);
      exp_t e;
      e.tag  = tag;
      e.q    = q;
      e.busy = busy;
      e.done = done;
      sb.push_back(e);
   endtask

   // One rising edge, then compare the oldest expectation on the falling edge.
   task automatic tick_check();
      exp_t e;
      @(posedge CK);
      @(negedge CK);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         check_all(e.tag, e.q, e.busy, e.done);
      end
   endtask

   initial begin
      RST = 1'b1; D = 8'hFF; EN = 1'b1; SE = 1'b0; SI = 2'b00; SHIFT_START = 1'b0;

      // Reset holds the register despite EN/D activity.
      #1;
      check_all("rst0", 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         push("rst", 8'h00, 1'b0, 1'b0);
         tick_check();
      end
      RST = 1'b0;

      // Functional load, then hold.
      EN = 1'b1; D = 8'hA5;
      push("load_a5", 8'hA5, 1'b0, 1'b0);
      tick_check();
      EN = 1'b0; D = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         push("hold_a5", 8'hA5, 1'b0, 1'b0);
         tick_check();
      end

      // External scan shifts.
      EN = 1'b1; D = 8'h00;
      push("load_00", 8'h00, 1'b0, 1'b0);
      tick_check();
      EN = 1'b0; SE = 1'b1; SI = 2'b11;
      push("se_shift1", 8'h11, 1'b0, 1'b0);
      tick_check();
      SI = 2'b01;
      push("se_shift2", 8'h23, 1'b0, 1'b0);
      tick_check();
      SE = 1'b0;

      // Auto-shift of A5 with zero scan-in.
      EN = 1'b1; D = 8'hA5;
      push("load_a5b", 8'hA5, 1'b0, 1'b0);
      tick_check();
      EN = 1'b0; SI = 2'b00; SHIFT_START = 1'b1;
      push("auto_start", 8'hA5, 1'b1, 1'b0);
      tick_check();
      SHIFT_START = 1'b0;
      push("auto_e1", 8'h4A, 1'b1, 1'b0); tick_check();
      push("auto_e2", 8'h84, 1'b1, 1'b0); tick_check();
      push("auto_e3", 8'h08, 1'b1, 1'b0); tick_check();
      push("auto_e4", 8'h00, 1'b0, 1'b1); tick_check();
      push("auto_idle", 8'h00, 1'b0, 1'b0); tick_check();

      // Shift wins over load.
      EN = 1'b1; D = 8'h11;
      push("load_11", 8'h11, 1'b0, 1'b0);
      tick_check();
      SE = 1'b1; EN = 1'b1; D = 8'hFF; SI = 2'b00;
      push("shift_over_load", 8'h22, 1'b0, 1'b0);
      tick_check();
      SE = 1'b0; EN = 1'b0;

      // Auto-shift with a re-pulsed start mid-shift; ones scanned in.
      SI = 2'b11; SHIFT_START = 1'b1;
      push("rp_start", 8'h22, 1'b1, 1'b0);
      tick_check();
      SHIFT_START = 1'b0;
      push("rp_e1", 8'h55, 1'b1, 1'b0); tick_check();
      SHIFT_START = 1'b1;
      push("rp_e2", 8'hBB, 1'b1, 1'b0); tick_check();
      SHIFT_START = 1'b0;
      push("rp_e3", 8'h77, 1'b1, 1'b0); tick_check();
      push("rp_e4", 8'hFF, 1'b0, 1'b1); tick_check();
      push("rp_idle1", 8'hFF, 1'b0, 1'b0); tick_check();
      push("rp_idle2", 8'hFF, 1'b0, 1'b0); tick_check();

      // Reset aborts an auto-shift with no DONE pulse.
      SI = 2'b00; SHIFT_START = 1'b1;
      push("ab_start", 8'hFF, 1'b1, 1'b0);
      tick_check();
      SHIFT_START = 1'b0;
      push("ab_e1", 8'hEE, 1'b1, 1'b0); tick_check();
      push("ab_e2", 8'hCC, 1'b1, 1'b0); tick_check();
      #2 RST = 1'b1;
      #1;
      check_all("ab_async", 8'h00, 1'b0, 1'b0);
      push("ab_rst", 8'h00, 1'b0, 1'b0);
      tick_check();
      RST = 1'b0;
      push("ab_nodone1", 8'h00, 1'b0, 1'b0); tick_check();
      push("ab_nodone2", 8'h00, 1'b0, 1'b0); tick_check();

      // A fresh start is accepted after the abort.
      SI = 2'b01; SHIFT_START = 1'b1;
      push("re_start", 8'h00, 1'b1, 1'b0);
      tick_check();
      SHIFT_START = 1'b0;
      push("re_e1", 8'h01, 1'b1, 1'b0); tick_check();
      push("re_e2", 8'h03, 1'b1, 1'b0); tick_check();
      push("re_e3", 8'h07, 1'b1, 1'b0); tick_check();
      push("re_e4", 8'h0F, 1'b0, 1'b1); tick_check();
      push("re_idle", 8'h0F, 1'b0, 1'b0); tick_check();

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scan_reg_bank.md
Name: scan_reg_bank

Overview:
- Parametrised multi-bit, multi-chain scan register. It is the next generation of the single-bit mux-scan flop cell.
- Adds a word-wide functional load enable, hold, N parallel scan chains, and a built-in shift sequencer that performs a full chain-length unload/load on one start pulse.
- Sits at block boundaries as a DFT-ready pipeline register. Test controllers drive SI/SO; functional logic drives D/Q.

Parameters:
- WIDTH, 8, total register bits. Must be a multiple of NUM_CHAINS and at least NUM_CHAINS.
- NUM_CHAINS, 1, number of independent scan chains.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.
- Derived: L = WIDTH/NUM_CHAINS (chain length); CW = max(1, clog2(L)) (counter width).

Ports:
- CK  in  1  rising-edge clock.
- RST  in  1  asynchronous reset, active-high.
- D  in  WIDTH  functional data.
- EN  in  1  functional load enable.
- SE  in  1  external scan enable; shifts every edge while high.
- SI  in  NUM_CHAINS  scan-in, one bit per chain.
- SHIFT_START  in  1  single-cycle request for an automatic L-edge shift.
- Q  out  WIDTH  register state.
- QN  out  WIDTH  ~Q.
- SO  out  NUM_CHAINS  scan-out per chain.
- SHIFT_BUSY  out  1  auto-shift in progress.
- SHIFT_DONE  out  1  one-cycle pulse after the final auto-shift edge.

Behaviour:
- Reset (RST=1, asynchronous, immediate):
  - Q=RESET_VAL, QN=~RESET_VAL, SO follows Q.
  - FSM=IDLE, counter=0, SHIFT_BUSY=0, SHIFT_DONE=0.
  - Reset asserted mid-shift aborts the shift; no SHIFT_DONE is produced.
- Chain mapping: chain c owns bits [c*L +: L].
  - On a shift edge: Q[c*L] <= SI[c]; Q[c*L+i] <= Q[c*L+i-1] for i=1..L-1.
  - SO[c] = Q[c*L+L-1], combinational from the register, so it is valid before each shift edge.
- Per-edge priority: shift (SE=1 or FSM=SHIFT) > load (EN=1: Q<=D) > hold.
  - SE and the sequencer together produce a single shift per edge, not two.
- Latency: Q updates on the same rising edge. QN and SO are zero-delay derivations of Q.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: SHIFT_START=1 -> SHIFT, counter<=L-1. Otherwise stay in IDLE.
  - SHIFT: shift every edge. If counter==0 -> DONE, else counter<=counter-1. This gives exactly L shift edges.
  - DONE: SHIFT_DONE=1 for this one cycle, then unconditionally -> IDLE. The register follows the SE/EN/hold rules in this cycle.
  - SHIFT_START while in SHIFT or DONE is ignored; it does not restart or extend the shift.
  - L=1: one shift edge, then DONE.
- SHIFT_BUSY = (state==SHIFT). SHIFT_DONE = (state==DONE). Both are registered state decodes with no combinational path from inputs.
- No X-propagation handling or timing checks in RTL; timing is owned by the library views.

Decomposition:
- Package scan_reg_pkg:
  - state enum {IDLE, SHIFT, DONE} (2-bit).
  - function chain_len(WIDTH, NUM_CHAINS).
  - function cnt_width(L) returning max(1, clog2(L)).
  - elaboration-time check: WIDTH % NUM_CHAINS == 0.
- Sub-module scan_shift_ctrl: FSM plus down-counter.
  - Inputs: CK, RST, SHIFT_START.
  - Outputs: shift_active, SHIFT_BUSY, SHIFT_DONE.
  - The top level holds the register array, chain muxing and the priority mux.

Test Plan (WIDTH=8, NUM_CHAINS=2, L=4, RESET_VAL=0):
1. RST=1 with CK toggling, D=8'hFF, EN=1 -> Q=8'h00, QN=8'hFF, SO=2'b00, BUSY=0, DONE=0 throughout.
2. SE=0, EN=1, D=8'hA5, one edge -> Q=8'hA5. Then EN=0, D=8'h3C, three edges -> Q stays 8'hA5.
3. Q=8'h00, SE=1, SI=2'b11, one edge -> Q=8'h11. Second edge with SI=2'b01 -> Q=8'h23.
4. Q=8'hA5, SI=2'b00, SHIFT_START pulse:
   - BUSY high for 4 cycles.
   - SO[0] before each edge = 0,1,0,1; SO[1] = 1,0,1,0.
   - Q=8'h00 after the 4th edge; DONE high exactly the next cycle; then IDLE.
5. SE=1, EN=1, D=8'hFF, SI=2'b00 from Q=8'h11 -> Q=8'h22 (shift wins over load). SHIFT_START re-pulsed at BUSY cycle 2 -> still exactly 4 shifts and one DONE.
6. Auto-shift of Q=8'hFF with SI=2'b00, RST pulsed after 2 edges -> Q=8'h00 immediately, BUSY=0, no DONE pulse. A new SHIFT_START is then accepted normally.
